// File: rtl/fanout_pkg.sv
// Shared types and default sizing for the one-to-many stream fork.
package fanout_pkg;

   typedef enum logic {
      FORK_LAZY  = 1'b0,
      FORK_EAGER = 1'b1
   } fork_mode_e;

   localparam int MAX_OUT            = 32;
   localparam int DEF_NUM_OUT        = 9;
   localparam int DEF_DATA_WIDTH     = 17;
   localparam int DEF_CNT_WIDTH      = 16;

endpackage

// File: rtl/fanout_fork_chan.sv
// One consumer lane of the fork: tracks eager acceptance and produces the
// lane's valid and its contribution to the token-retire condition.
module fanout_fork_chan
   import fanout_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_buf_valid,
   input  logic       i_act,
   input  fork_mode_e i_mode,
   input  logic       i_all_done,
   input  logic       i_retire,
   input  logic       i_ready,
   output logic       o_valid,
   output logic       o_done
);

   logic r_taken;

   // Lazy lanes fire together once every active lane is ready; eager lanes fire until taken.
   always_comb begin
      if (i_mode == FORK_EAGER) o_valid = i_buf_valid & i_act & ~r_taken;
      else                      o_valid = i_buf_valid & i_act & i_all_done;
   end

   assign o_done = ~i_act | r_taken | i_ready;

   always_ff @(posedge clk) begin
      if (reset)                                         r_taken <= 1'b0;
      else if (i_retire)                                 r_taken <= 1'b0;
      else if (i_mode == FORK_EAGER && o_valid && i_ready) r_taken <= 1'b1;
   end

endmodule

// File: rtl/fanout_fork.sv
// Registered one-to-many stream fork: a one-entry holding register broadcast
// to NUM_OUT lanes under a per-token latched mask, with a retired-token count.
module fanout_fork
   import fanout_pkg::*;
#(
   parameter int NUM_OUT    = DEF_NUM_OUT,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_OUT-1:0]    cfg_en,
   input  logic [NUM_OUT-1:0]    cfg_sel,
   input  logic                  cfg_eager,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]    out_valid,
   input  logic [NUM_OUT-1:0]    out_ready,
   output logic [CNT_WIDTH-1:0]  tok_count
);

   logic                  r_buf_valid;
   logic [DATA_WIDTH-1:0] r_buf_data;
   logic [NUM_OUT-1:0]    r_act;
   fork_mode_e            r_mode;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic [NUM_OUT-1:0]    w_done;
   logic                  w_all_done;
   logic                  w_retire;
   logic                  w_load;

   assign w_all_done = &w_done;
   assign w_retire   = r_buf_valid & w_all_done;
   assign in_ready   = ~reset & (~r_buf_valid | w_retire);
   assign w_load     = in_valid & in_ready;

   assign out_data   = r_buf_data;
   assign tok_count  = r_cnt;

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
      fanout_fork_chan u_chan (
         .clk         (clk),
         .reset       (reset),
         .i_buf_valid (r_buf_valid),
         .i_act       (r_act[g]),
         .i_mode      (r_mode),
         .i_all_done  (w_all_done),
         .i_retire    (w_retire),
         .i_ready     (out_ready[g]),
         .o_valid     (out_valid[g]),
         .o_done      (w_done[g])
      );
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_data  <= '0;
         r_act       <= '0;
         r_mode      <= FORK_LAZY;
         r_cnt       <= '0;
      end else begin
         if (w_load) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= in_data;
            r_act       <= cfg_en & cfg_sel;
            r_mode      <= fork_mode_e'(cfg_eager);
         end else if (w_retire) begin
            r_buf_valid <= 1'b0;
         end
         if (w_retire && r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fanout_fork.sv
// Self-checking bench for fanout_fork: directed scenarios plus random traffic
// compared each cycle against a mask-level behavioural model.
module tb_fanout_fork;
   import fanout_pkg::*;

   localparam int N   = 9;
   localparam int DW  = 17;
   localparam int CW  = 16;
   localparam int CWS = 4;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic [N-1:0]  cfg_en    = '0;
   logic [N-1:0]  cfg_sel   = '0;
   logic          cfg_eager = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          in_valid  = 1'b0;
   logic [N-1:0]  out_ready = '0;

   logic           in_ready,  in_ready_s;
   logic [DW-1:0]  out_data,  out_data_s;
   logic [N-1:0]   out_valid, out_valid_s;
   logic [CW-1:0]  tok_count;
   logic [CWS-1:0] tok_count_s;

   fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
      .cfg_eager(cfg_eager), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .tok_count(tok_count)
   );

   fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CWS)) dut_sat (
      .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
      .cfg_eager(cfg_eager), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s),
      .out_ready(out_ready), .tok_count(tok_count_s)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the held token as a record of data, mask, mode and accepted lanes.
   bit          m_valid = 1'b0;
   bit [DW-1:0] m_data  = '0;
   bit [N-1:0]  m_mask  = '0;
   bit [N-1:0]  m_taken = '0;
   bit          m_eager = 1'b0;
   int          m_cnt   = 0;

   bit [N-1:0]  e_ov;
   bit          e_ret;
   bit          e_ir;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      @(negedge clk);
      e_ov  = '0;
      e_ret = 1'b0;
      if (m_valid) begin
         if (m_eager) begin
            e_ov  = m_mask & ~m_taken;
            e_ret = ((e_ov & ~out_ready) == '0);
         end else begin
            e_ret = ((m_mask & ~out_ready) == '0);
            e_ov  = e_ret ? m_mask : '0;
         end
      end
      e_ir = !reset && (!m_valid || e_ret);
      chk({tag, ".in_ready"},   64'(in_ready),   64'(e_ir));
      chk({tag, ".in_ready_s"}, 64'(in_ready_s), 64'(e_ir));
      if (!reset) begin
         chk({tag, ".out_valid"},   64'(out_valid),   64'(e_ov));
         chk({tag, ".out_valid_s"}, 64'(out_valid_s), 64'(e_ov));
         chk({tag, ".out_data"},    64'(out_data),    64'(m_data));
         chk({tag, ".out_data_s"},  64'(out_data_s),  64'(m_data));
         chk({tag, ".tok_count"},   64'(tok_count),   64'(m_cnt));
         chk({tag, ".tok_count_s"}, 64'(tok_count_s), 64'((m_cnt > 15) ? 15 : m_cnt));
      end
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_data = '0; m_mask = '0; m_taken = '0; m_eager = 1'b0; m_cnt = 0;
      end else begin
         if (m_valid && m_eager) m_taken |= e_ov & out_ready;
         if (e_ret) begin
            m_valid = 1'b0;
            m_taken = '0;
            if (m_cnt < 65535) m_cnt++;
         end
         if (in_valid && e_ir) begin
            m_valid = 1'b1;
            m_data  = in_data;
            m_mask  = cfg_en & cfg_sel;
            m_eager = cfg_eager;
            m_taken = '0;
         end
      end
      #1;
   endtask

   initial begin
      // Reset and idle.
      reset = 1'b1;
      tick("rst0");
      tick("rst1");
      reset = 1'b0;
      tick("idle");

      // Eager: ready rises lane by lane, each valid drops after its own handshake.
      cfg_en = '1; cfg_sel = '1; cfg_eager = 1'b1;
      in_valid = 1'b1; in_data = 17'h00A5; out_ready = '0;
      tick("eager_load");
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         out_ready = N'((1 << (i + 1)) - 1);
         tick("eager_hs");
      end
      out_ready = '0;
      tick("eager_done");

      // Lazy: mask 00F, partial readiness for three cycles, then all ready.
      cfg_en = 9'h00F; cfg_sel = '1; cfg_eager = 1'b0;
      in_valid = 1'b1; in_data = 17'h1_2345;
      tick("lazy_load");
      in_valid = 1'b0; out_ready = 9'h007;
      for (int i = 0; i < 3; i++) tick("lazy_wait");
      out_ready = 9'h00F;
      tick("lazy_fire");
      tick("lazy_idle");

      // Empty mask: five back-to-back dropped tokens.
      cfg_en = '1; cfg_sel = '0; out_ready = '0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = DW'($urandom);
         tick("drop");
      end
      in_valid = 1'b0;
      tick("drop_tail");

      // Streaming: 100 tokens, all consumers ready.
      cfg_en = '1; cfg_sel = '1; cfg_eager = 1'b0; out_ready = '1;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_data = DW'(i);
         tick("stream");
      end
      in_valid = 1'b0;
      tick("stream_tail");

      // Config change while a token is held.
      cfg_en = 9'h0F0; cfg_sel = '1; cfg_eager = 1'b1; out_ready = '0;
      in_valid = 1'b1; in_data = 17'h0_0123;
      tick("cfg_load");
      in_valid = 1'b0; cfg_en = '0;
      tick("cfg_hold0");
      tick("cfg_hold1");
      out_ready = '1; in_valid = 1'b1; in_data = 17'h0_0055;
      tick("cfg_swap");
      in_valid = 1'b0;
      tick("cfg_newmask");
      tick("cfg_idle");

      // Reset mid-token with two lanes already taken.
      cfg_en = '1; cfg_sel = '1; cfg_eager = 1'b1; out_ready = '0;
      in_valid = 1'b1; in_data = 17'h1_FFFF;
      tick("rmid_load");
      in_valid = 1'b0; out_ready = 9'h003;
      tick("rmid_take");
      out_ready = '0; reset = 1'b1;
      tick("rmid_rst");
      reset = 1'b0;
      tick("rmid_post");
      in_valid = 1'b1; in_data = 17'h0_003C;
      tick("rmid_reload");
      in_valid = 1'b0;
      tick("rmid_fresh");

      // Random traffic; also drives the 4-bit counter into saturation.
      for (int i = 0; i < 400; i++) begin
         cfg_en    = N'($urandom);
         cfg_sel   = N'($urandom);
         cfg_eager = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
         tick("rand");
      end
      in_valid = 1'b0; out_ready = '1;
      tick("rand_tail0");
      tick("rand_tail1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
